// File: rtl/core_regfile_wb_pkg.sv
// Shared uarch types and constants for the banked register file.
package core_regfile_wb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_NUM_W = 4;
    localparam int unsigned PHYS_W    = 5;
    localparam int unsigned MODE_W    = 5;
    localparam int unsigned FLAGS_W   = 4;
    localparam int unsigned PHYS_REGS = 31;

    typedef logic [REG_NUM_W-1:0] reg_num;
    typedef logic [XLEN-1:0]      word;
    typedef logic [FLAGS_W-1:0]   psr_flags;
    typedef logic [MODE_W-1:0]    psr_mode;
    typedef logic [PHYS_W-1:0]    phys_reg;

    localparam psr_mode MODE_USR = 5'b10000;
    localparam psr_mode MODE_FIQ = 5'b10001;
    localparam psr_mode MODE_IRQ = 5'b10010;
    localparam psr_mode MODE_SVC = 5'b10011;
    localparam psr_mode MODE_ABT = 5'b10111;
    localparam psr_mode MODE_UND = 5'b11011;
    localparam psr_mode MODE_SYS = 5'b11111;

    localparam reg_num R15           = 4'd15;
    localparam word    PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Physical layout: user r0-r14 at 0-14, FIQ r8-r14 at 15-21, then r13/r14 pairs.
    // Slot 30 is the dummy target for R15, which is never stored.
    localparam phys_reg FIQ_BASE      = 5'd15;
    localparam phys_reg IRQ_BASE      = 5'd22;
    localparam phys_reg SVC_BASE      = 5'd24;
    localparam phys_reg ABT_BASE      = 5'd26;
    localparam phys_reg UND_BASE      = 5'd28;
    localparam phys_reg PHYS_R15_SLOT = 5'd30;

endpackage

// File: rtl/core_regfile_bank_map.sv
// Maps (mode, architectural register) to a physical register index.
module core_regfile_bank_map
    import core_regfile_wb_pkg::*;
(
    input  logic [4:0] mode,
    input  logic [3:0] rn,
    output logic [4:0] phys_c
);

    always_comb begin
        phys_c = PHYS_W'(rn);
        if (rn == R15) begin
            phys_c = PHYS_R15_SLOT;
        end else if ((mode == MODE_FIQ) && (rn >= 4'd8)) begin
            phys_c = FIQ_BASE + PHYS_W'(rn - 4'd8);
        end else if (rn >= 4'd13) begin
            // USR, SYS and undefined encodings keep the user-bank index
            case (mode)
                MODE_IRQ: phys_c = IRQ_BASE + PHYS_W'(rn - 4'd13);
                MODE_SVC: phys_c = SVC_BASE + PHYS_W'(rn - 4'd13);
                MODE_ABT: phys_c = ABT_BASE + PHYS_W'(rn - 4'd13);
                MODE_UND: phys_c = UND_BASE + PHYS_W'(rn - 4'd13);
                default:  phys_c = PHYS_W'(rn);
            endcase
        end
    end

endmodule

// File: rtl/core_regfile_wb.sv
// Mode-banked GPR file with NZCV flags, two registered read ports and R15 branch pulse.
// Optional same-edge write-to-read forwarding: define CORE_REGFILE_BYPASS_EN.
module core_regfile_wb
    import core_regfile_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  mode,
    input  logic        writeback,
    input  logic [3:0]  rd,
    input  logic [31:0] wr_value,
    input  logic        update_flags,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [31:0] pc_plus8,
    output logic [31:0] rd_a,
    output logic [31:0] rd_b,
    output logic [3:0]  flags,
    output logic        branch,
    output logic [31:0] branch_target
);

    phys_reg wr_idx;
    phys_reg a_idx;
    phys_reg b_idx;
    word     phys_q [PHYS_REGS];
    word     a_data;
    word     b_data;
    logic    wr_en;
    logic    pc_wr;

    core_regfile_bank_map u_map_wr (.mode(mode), .rn(rd), .phys_c(wr_idx));
    core_regfile_bank_map u_map_a  (.mode(mode), .rn(ra), .phys_c(a_idx));
    core_regfile_bank_map u_map_b  (.mode(mode), .rn(rb), .phys_c(b_idx));

    assign wr_en = writeback && (rd != R15);
    assign pc_wr = writeback && (rd == R15);

    // Read data selection ahead of the output registers
    always_comb begin
        a_data = phys_q[a_idx];
        b_data = phys_q[b_idx];
`ifdef CORE_REGFILE_BYPASS_EN
        if (wr_en && (wr_idx == a_idx)) a_data = wr_value;
        if (wr_en && (wr_idx == b_idx)) b_data = wr_value;
`endif
        if (ra == R15) a_data = pc_plus8;
        if (rb == R15) b_data = pc_plus8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                phys_q[i] <= '0;
            end
        end else if (wr_en) begin
            phys_q[wr_idx] <= wr_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a          <= '0;
            rd_b          <= '0;
            flags         <= '0;
            branch        <= 1'b0;
            branch_target <= '0;
        end else begin
            rd_a   <= a_data;
            rd_b   <= b_data;
            branch <= pc_wr;
            if (update_flags) flags <= alu_flags;
            if (pc_wr) branch_target <= wr_value & PC_ALIGN_MASK;
        end
    end

endmodule
